// File: rtl/axis_step_ctrl.sv
// axis_step_ctrl: single-axis step/direction pulse generator with a
// register interface, homing on a reference sensor, and driver-fault abort.
//
// Ports
//   Clk, nRst        clock, asynchronous active-low reset
//   WrEn/Addr/WrData register write strobe, address, data
//   RdData           registered read data (one Clk after Addr is sampled)
//   Ref              home sensor (async, falling edge = home)
//   Protect          driver fault (async, high = fault)
//   PlsOut           step pulse, PW cycles high at the start of each period
//   Dir              direction output (DirCmd ^ DirRev, held while busy)
//   Busy             high while not IDLE
//   Pos              signed position counter, wraps modulo 2^POS_W
module axis_step_ctrl #(
    parameter int POS_W = 20,
    parameter int DIV_W = 16,
    parameter int PW    = 4
) (
    input  logic             Clk,
    input  logic             nRst,
    input  logic             WrEn,
    input  logic [2:0]       Addr,
    input  logic [15:0]      WrData,
    output logic [15:0]      RdData,
    input  logic             Ref,
    input  logic             Protect,
    output logic             PlsOut,
    output logic             Dir,
    output logic             Busy,
    output logic [POS_W-1:0] Pos
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} stepStateT;

    localparam logic [DIV_W-1:0] MinPeriod = DIV_W'(2 * PW);
    localparam logic [DIV_W-1:0] PwLast    = DIV_W'(PW - 1);

    stepStateT         state, nextState;
    logic [1:0]        refSync, protSync;
    logic              refPrev;
    logic              ctrlMode, ctrlDirCmd, ctrlDirRev, ctrlRefEn;
    logic [DIV_W-1:0]  divReg, curPeriod, cnt;
    logic [POS_W-1:0]  stepsReg, remain;
    logic              cmdWork, modeWork, stopPend;
    logic              fault, refDone;
    logic [15:0]       refPos;

    logic refS, protS;
    logic wrCtrl, startStb, stopStb, posClr, refClr, stopReq;
    logic dirCmdEff, dirRevEff, modeEff, startOk, periodEnd;
    logic enterRun, newPeriod, pulseStart, homeEv, stepUp;
    logic [DIV_W-1:0] periodEff;

    assign refS  = refSync[1];
    assign protS = protSync[1];

    // CTRL strobes and the CTRL value as it will be after this cycle's write,
    // so a Start write latches the direction/mode written alongside it.
    assign wrCtrl    = WrEn && (Addr == 3'd0);
    assign startStb  = wrCtrl && WrData[0];
    assign stopStb   = wrCtrl && WrData[1];
    assign posClr    = wrCtrl && WrData[6];
    assign refClr    = wrCtrl && WrData[7];
    assign modeEff   = wrCtrl ? WrData[2] : ctrlMode;
    assign dirCmdEff = wrCtrl ? WrData[3] : ctrlDirCmd;
    assign dirRevEff = wrCtrl ? WrData[4] : ctrlDirRev;

    assign stopReq   = stopStb || stopPend;
    assign periodEff = (divReg < MinPeriod) ? MinPeriod : divReg;
    assign periodEnd = (cnt == curPeriod - DIV_W'(1));
    assign startOk   = startStb && !stopStb && !fault && !protS &&
                       (modeEff || (stepsReg != '0));

    // State register
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic. Stop only takes effect once the high phase is over
    // (cnt >= PW-1); since the period is at least 2*PW this also pre-empts
    // the next period start.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (startOk) nextState = RUN;
            RUN: begin
                if (protS)                                  nextState = IDLE;
                else if (stopReq && (cnt >= PwLast))        nextState = HALT;
                else if (periodEnd && !modeWork && (remain == '0))
                                                            nextState = HALT;
            end
            HALT:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        Busy       = (state != IDLE);
        enterRun   = (state == IDLE) && (nextState == RUN);
        newPeriod  = (state == RUN) && (nextState == RUN) && periodEnd;
        pulseStart = enterRun || newPeriod;
        stepUp     = enterRun ? dirCmdEff : cmdWork;
        homeEv     = refPrev && !refS && ctrlRefEn && !refDone;
    end

    // Synchronisers and register file
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            refSync    <= '0;
            protSync   <= '0;
            refPrev    <= 1'b0;
            ctrlMode   <= 1'b0;
            ctrlDirCmd <= 1'b0;
            ctrlDirRev <= 1'b0;
            ctrlRefEn  <= 1'b0;
            divReg     <= MinPeriod;
            stepsReg   <= '0;
        end else begin
            refSync  <= {refSync[0], Ref};
            protSync <= {protSync[0], Protect};
            refPrev  <= refSync[1];
            if (WrEn) begin
                case (Addr)
                    3'd0: begin
                        ctrlMode   <= WrData[2];
                        ctrlDirCmd <= WrData[3];
                        ctrlDirRev <= WrData[4];
                        ctrlRefEn  <= WrData[5];
                    end
                    3'd1: divReg <= DIV_W'(WrData);
                    3'd2: stepsReg[15:0] <= WrData;
                    3'd3: stepsReg[POS_W-1:16] <= WrData[POS_W-17:0];
                    default: ;
                endcase
            end
        end
    end

    // Pulse timing and working copies
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            cnt       <= '0;
            curPeriod <= MinPeriod;
            remain    <= '0;
            cmdWork   <= 1'b0;
            modeWork  <= 1'b0;
            stopPend  <= 1'b0;
            PlsOut    <= 1'b0;
            Dir       <= 1'b0;
        end else begin
            if (pulseStart)        cnt <= '0;
            else if (state == RUN) cnt <= cnt + DIV_W'(1);
            else                   cnt <= '0;

            if (pulseStart) curPeriod <= periodEff;

            if (enterRun) begin
                remain   <= stepsReg - POS_W'(1);
                cmdWork  <= dirCmdEff;
                modeWork <= modeEff;
            end else if (newPeriod) begin
                remain <= remain - POS_W'(1);
            end

            if ((state == RUN) && (nextState == RUN)) stopPend <= stopPend || stopStb;
            else                                      stopPend <= 1'b0;

            PlsOut <= pulseStart || ((nextState == RUN) && PlsOut && (cnt < PwLast));

            // Direction tracks CTRL only while idle; it is frozen for a move.
            if (state == IDLE) Dir <= dirCmdEff ^ dirRevEff;
        end
    end

    // Position, homing, fault, read-back
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            Pos     <= '0;
            refPos  <= '0;
            refDone <= 1'b0;
            fault   <= 1'b0;
            RdData  <= '0;
        end else begin
            // Clears win over a step issued in the same cycle.
            if (homeEv || posClr) Pos <= '0;
            else if (pulseStart)  Pos <= stepUp ? Pos + POS_W'(1) : Pos - POS_W'(1);

            if (homeEv) refPos <= Pos[15:0];

            if (refClr)      refDone <= 1'b0;
            else if (homeEv) refDone <= 1'b1;

            // A fault still present keeps Fault set through a RefClr.
            if (protS)       fault <= 1'b1;
            else if (refClr) fault <= 1'b0;

            case (Addr)
                3'd0:    RdData <= {12'h0, fault, refDone, Busy, refS};
                3'd1:    RdData <= Pos[15:0];
                3'd2:    RdData <= 16'(Pos[POS_W-1:16]);
                3'd3:    RdData <= refPos;
                default: RdData <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_step_ctrl.sv
// Self-checking bench for axis_step_ctrl: table of counted moves, hand
// sequences for stop/homing/fault/reset, and random counted moves checked
// against an arithmetic model of period, pulse count and position.
module tb_axis_step_ctrl;

    localparam int POS_W = 20;
    localparam int DIV_W = 16;
    localparam int PW    = 4;

    logic             Clk, nRst, WrEn, Ref, Protect;
    logic [2:0]       Addr;
    logic [15:0]      WrData, RdData;
    logic             PlsOut, Dir, Busy;
    logic [POS_W-1:0] Pos;

    axis_step_ctrl #(.POS_W(POS_W), .DIV_W(DIV_W), .PW(PW)) dut (
        .Clk(Clk), .nRst(nRst), .WrEn(WrEn), .Addr(Addr), .WrData(WrData),
        .RdData(RdData), .Ref(Ref), .Protect(Protect), .PlsOut(PlsOut),
        .Dir(Dir), .Busy(Busy), .Pos(Pos)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         div;
        bit         wrDiv;
        int         steps;
        bit         cmd;
        bit         rev;
        bit         clr;
        int         expPulses;
        int         expPeriod;
        logic [19:0] expPos;
    } moveVecT;

    moveVecT tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        WrEn = 1'b1; Addr = a; WrData = d;
        tick();
        WrEn = 1'b0; WrData = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        Addr = a;
        tick();
        d = RdData;
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 500 && Busy; i++) tick();
        chk({name, " idle"}, Busy, 0);
    endtask

    // Run one counted move and measure it sample by sample.
    task automatic runMove(input string tag, input moveVecT v);
        int rises, lastRise, highCnt, busyLow, dirBad;
        bit prevP;
        logic [15:0] d;
        logic [19:0] st;
        st = 20'(v.steps);
        if (v.clr)   wr(3'd0, 16'h0040);
        if (v.wrDiv) wr(3'd1, 16'(v.div));
        wr(3'd2, st[15:0]);
        wr(3'd3, {12'h0, st[19:16]});
        wr(3'd0, {11'h0, v.rev, v.cmd, 3'b001});
        chk({tag, " first pulse"}, PlsOut, 1);
        rises = 0; lastRise = -1; highCnt = 0; busyLow = -1; dirBad = 0; prevP = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!Busy) begin busyLow = k; break; end
            if (PlsOut && !prevP) begin rises++; lastRise = k; end
            if (PlsOut) highCnt++;
            if (Dir !== (v.cmd ^ v.rev)) dirBad++;
            prevP = PlsOut;
            tick();
        end
        chk({tag, " pulses"}, rises, v.expPulses);
        chk({tag, " last rise"}, lastRise, (v.expPulses - 1) * v.expPeriod);
        chk({tag, " high cycles"}, highCnt, v.expPulses * PW);
        chk({tag, " busy low"}, busyLow, v.expPulses * v.expPeriod + 1);
        chk({tag, " dir"}, dirBad, 0);
        chk({tag, " pos"}, Pos, v.expPos);
        rd(3'd1, d);
        chk({tag, " rd pos lo"}, d, v.expPos[15:0]);
        rd(3'd2, d);
        chk({tag, " rd pos hi"}, d, {12'h0, v.expPos[19:16]});
    endtask

    initial begin
        logic [15:0] d;
        logic [19:0] modelPos;
        moveVecT rv;
        int hi, bad;

        nRst = 1'b0; WrEn = 1'b0; Addr = '0; WrData = '0; Ref = 1'b1; Protect = 1'b0;
        tickN(3);
        chk("reset PlsOut", PlsOut, 0);
        chk("reset Dir", Dir, 0);
        chk("reset Busy", Busy, 0);
        chk("reset Pos", Pos, 0);
        chk("reset RdData", RdData, 0);
        nRst = 1'b1;
        tickN(4);

        //          div wrDiv steps cmd rev clr pulses period pos
        tbl[0] = '{0,  0, 2, 1, 0, 1, 2, 8,  20'h00002};
        tbl[1] = '{10, 1, 5, 1, 0, 1, 5, 10, 20'h00005};
        tbl[2] = '{3,  1, 2, 1, 0, 1, 2, 8,  20'h00002};
        tbl[3] = '{0,  1, 1, 0, 0, 1, 1, 8,  20'hFFFFF};
        tbl[4] = '{12, 1, 3, 0, 1, 0, 3, 12, 20'hFFFFC};
        tbl[5] = '{8,  1, 4, 1, 1, 0, 4, 8,  20'h00000};
        for (int i = 0; i < 6; i++) runMove($sformatf("vec%0d", i), tbl[i]);

        // Stop during the high phase; a CTRL write while busy must not move Dir.
        wr(3'd0, 16'h0040);
        wr(3'd1, 16'd20);
        wr(3'd0, 16'h000D);
        chk("stop first pulse", PlsOut, 1);
        wr(3'd0, 16'h0006);
        chk("stop dir held", Dir, 1);
        hi = 1;
        for (int i = 0; i < 50 && PlsOut; i++) begin hi++; tick(); end
        chk("stop high width", hi, PW);
        chk("stop halt busy", Busy, 1);
        tick();
        chk("stop idle busy", Busy, 0);
        chk("stop pos", Pos, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin if (PlsOut) bad++; tick(); end
        chk("stop no pulse", bad, 0);

        // Start with Stop, and counted Start with STEPS=0, both stay idle.
        wr(3'd0, 16'h0007);
        tick();
        chk("start+stop idle", Busy, 0);
        wr(3'd2, 16'h0000);
        wr(3'd3, 16'h0000);
        wr(3'd0, 16'h0001);
        tick();
        chk("zero steps idle", Busy, 0);

        // Start while busy is ignored.
        wr(3'd0, 16'h0040);
        wr(3'd2, 16'd2);
        wr(3'd0, 16'h0009);
        tickN(5);
        wr(3'd0, 16'h0009);
        chk("restart ignored pls", PlsOut, 0);
        waitIdle("restart");
        chk("restart pos", Pos, 2);

        // Homing during a continuous run, period 40.
        wr(3'd0, 16'h0040);
        wr(3'd1, 16'd40);
        wr(3'd0, 16'h002D);
        tickN(85);
        chk("home prior pos", Pos, 3);
        Ref = 1'b0;
        tickN(5);
        chk("home pos cleared", Pos, 0);
        rd(3'd0, d);
        chk("home status", d, 16'h0006);
        rd(3'd3, d);
        chk("home refpos", d, 16'd3);
        Ref = 1'b1;
        tickN(33);
        chk("home pos after step", Pos, 1);
        Ref = 1'b0;
        tickN(10);
        chk("home second edge", Pos, 1);
        rd(3'd3, d);
        chk("home refpos kept", d, 16'd3);
        wr(3'd0, 16'h002E);
        waitIdle("home stop");
        wr(3'd0, 16'h0080);
        rd(3'd0, d);
        chk("home refclr status", d, 16'h0000);
        Ref = 1'b1;
        tickN(3);

        // Fault abort
        wr(3'd1, 16'd20);
        wr(3'd0, 16'h000D);
        Protect = 1'b1;
        tickN(3);
        chk("fault pls low", PlsOut, 0);
        chk("fault busy", Busy, 0);
        rd(3'd0, d);
        chk("fault status", d, 16'h0009);
        Protect = 1'b0;
        tickN(3);
        wr(3'd0, 16'h000D);
        tickN(2);
        chk("fault start ignored", Busy, 0);
        wr(3'd0, 16'h0080);
        rd(3'd0, d);
        chk("fault cleared", d, 16'h0001);
        wr(3'd0, 16'h000D);
        chk("fault restart", Busy, 1);
        wr(3'd0, 16'h0006);
        waitIdle("fault stop");

        // Random counted moves against an arithmetic model.
        modelPos = '0;
        for (int i = 0; i < 8; i++) begin
            rv.div   = $urandom_range(0, 20);
            rv.wrDiv = 1;
            rv.steps = $urandom_range(1, 6);
            rv.cmd   = 1'($urandom_range(0, 1));
            rv.rev   = 1'($urandom_range(0, 1));
            rv.clr   = (i == 0) || ($urandom_range(0, 3) == 0);
            if (rv.clr) modelPos = '0;
            modelPos = rv.cmd ? modelPos + 20'(rv.steps) : modelPos - 20'(rv.steps);
            rv.expPulses = rv.steps;
            rv.expPeriod = (rv.div < 2 * PW) ? 2 * PW : rv.div;
            rv.expPos    = modelPos;
            runMove($sformatf("rnd%0d", i), rv);
        end

        // Reset asserted in the middle of a pulse.
        wr(3'd1, 16'd20);
        wr(3'd0, 16'h000D);
        tick();
        #2 nRst = 1'b0;
        #1;
        chk("midreset PlsOut", PlsOut, 0);
        chk("midreset Busy", Busy, 0);
        chk("midreset Pos", Pos, 0);
        chk("midreset Dir", Dir, 0);
        #3 nRst = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin if (PlsOut || Busy) bad++; tick(); end
        chk("midreset quiet", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_step_ctrl.md
AXIS_STEP_CTRL -- requirements
Module: axis_step_ctrl

Interface
REQ-001 SHALL have parameter POS_W, default 20, position counter width (range 17..32).
REQ-002 SHALL have parameter DIV_W, default 16, step period divider width.
REQ-003 SHALL have parameter PW, default 4, PlsOut high time in Clk cycles (≥1).
REQ-004 SHALL have port Clk  input  1  the single system clock; all state on its rising edge.
REQ-005 SHALL have port nRst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port WrEn  input  1  one-cycle register write strobe.
REQ-007 SHALL have port Addr  input  3  register address for writes and reads.
REQ-008 SHALL have port WrData  input  16  write data.
REQ-009 SHALL have port RdData  output  16  registered read data.
REQ-010 SHALL have port Ref  input  1  asynchronous home sensor.
REQ-011 SHALL have port Protect  input  1  asynchronous driver fault, high = fault.
REQ-012 SHALL have port PlsOut  output  1  step pulse.
REQ-013 SHALL have port Dir  output  1  direction, DirCmd XOR DirRev.
REQ-014 SHALL have port Busy  output  1  high while not IDLE.
REQ-015 SHALL have port Pos  output  POS_W  signed position counter.

Function
REQ-016 SHALL decode writes: Addr0 CTRL; Addr1 DIV[DIV_W-1:0]; Addr2 STEPS[15:0]; Addr3 STEPS[POS_W-1:16].
REQ-017 SHALL decode CTRL bits: 0 Start, 1 Stop, 6 PosClr, 7 RefClr (self-clearing strobes); 2 Mode (0 counted, 1 continuous), 3 DirCmd, 4 DirRev, 5 RefEn (held).
REQ-018 SHALL return on read, one Clk after Addr is sampled: 0 status {12'h0, Fault, RefDone, Busy, RefSync}; 1 Pos[15:0]; 2 Pos[POS_W-1:16] zero-extended; 3 RefPos[15:0]; others 0.
REQ-019 SHALL double-flop synchronise Ref and Protect before use.
REQ-020 SHALL implement states IDLE, RUN, HALT.
REQ-021 SHALL leave IDLE for RUN on Start only when Fault=0 and (Mode=1 or STEPS≠0); otherwise remain IDLE.
REQ-022 SHALL latch Dir, Mode and STEPS into working copies on entry to RUN; CTRL writes while Busy do not change Dir.
REQ-023 SHALL clamp the effective period to max(DIV, 2*PW); a DIV write during RUN takes effect at the next period start.
REQ-024 SHALL drive PlsOut high for the first PW cycles of each period; first rising edge is one Clk after Start.
REQ-025 SHALL update Pos by ±1 (+ when DirCmd=1) on the cycle PlsOut rises, wrapping modulo 2^POS_W.
REQ-026 SHALL, in counted mode, decrement the remaining count per pulse and go to HALT at the end of the period in which it reaches 0.
REQ-027 SHALL, on Stop in RUN, go to HALT after the current PlsOut high phase completes (no truncated pulse).
REQ-028 SHALL go from HALT to IDLE after one Clk.
REQ-029 SHALL, on synchronised Protect high, force PlsOut low the next Clk, go to IDLE, and set sticky Fault; Fault clears only on RefClr or reset.
REQ-030 SHALL, on a falling edge of the synchronised Ref with RefEn=1 and RefDone=0, capture Pos[15:0] into RefPos, clear Pos to 0, and set RefDone.
REQ-031 SHALL give clear priority: home clear or PosClr over pulse increment in the same cycle.
REQ-032 SHALL clear RefDone and Fault on RefClr.
REQ-033 SHALL ignore Start while Busy=1; on simultaneous Start and Stop, Stop wins.

Reset
REQ-034 SHALL, while nRst is low, hold all outputs and registers at 0: PlsOut, Dir, Busy, Pos, RdData, RefDone, Fault, RefPos, CTRL, STEPS, with DIV reset to 2*PW, in state IDLE.
REQ-035 SHALL, on reset asserted mid-pulse, drop PlsOut immediately and never emit a partial pulse after release.

Verification
REQ-036 SHALL verify counted move: DIV=10, STEPS=5, DirCmd=1, Start -> 5 pulses of 4 cycles each 10 cycles apart, Pos=5, Busy low 2 cycles after the last period.
REQ-037 SHALL verify wrap: Pos=0, DirCmd=0, STEPS=1 -> Pos=0xFFFFF (POS_W=20).
REQ-038 SHALL verify clamp: DIV=3, PW=4 -> period of 8 cycles.
REQ-039 SHALL verify homing: continuous run with RefEn=1, Ref 1→0 -> Pos=0, RefPos=prior Pos, RefDone=1; a second Ref edge does not clear.
REQ-040 SHALL verify fault: Protect high during run -> PlsOut low within 3 Clk, Busy=0, Fault=1, Start ignored until RefClr.
REQ-041 SHALL verify Stop during high phase -> pulse completes its PW cycles, then HALT, then IDLE.
